// File: rtl/alu_sequencer_if.sv
// Command handshake bundle for alu_sequencer.
// The master issues commands; the sequencer (slave) accepts them.
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_rdest;
    logic [3:0] cmd_rsrc;
    logic [7:0] cmd_imm;
    logic       cmd_imm_mode;
    logic       cmd_set_flags;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rdest,
        output cmd_rsrc,
        output cmd_imm,
        output cmd_imm_mode,
        output cmd_set_flags,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rdest,
        input  cmd_rsrc,
        input  cmd_imm,
        input  cmd_imm_mode,
        input  cmd_set_flags,
        output cmd_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command through register read, ALU pass(es) and writeback.
// ALU_SEQ_MULTISHIFT_EN enables the multi-pass SHIFT state for LSH.
module alu_sequencer (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_sequencer_if.slave        cmd,
    output logic [3:0]            rf_raddr_a,
    output logic [3:0]            rf_raddr_b,
    input  logic [15:0]           rf_rdata_a,
    input  logic [15:0]           rf_rdata_b,
    output logic                  rf_we,
    output logic [3:0]            rf_waddr,
    output logic [15:0]           rf_wdata,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [3:0]            alu_op,
    output logic                  alu_imm_mode,
    output logic                  alu_carry_in,
    output logic                  alu_update_flags,
    input  logic [15:0]           alu_result,
    input  logic [4:0]            alu_flags,
    output logic [4:0]            psr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [3:0] OP_LSH = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1011;

`ifdef ALU_SEQ_MULTISHIFT_EN
    typedef enum logic [2:0] {IDLE, READ, EXEC, SHIFT, WB} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, EXEC, WB} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  rdest_q, rdest_d;
    logic [3:0]  rsrc_q, rsrc_d;
    logic [7:0]  imm_q, imm_d;
    logic        imm_mode_q, imm_mode_d;
    logic        set_flags_q, set_flags_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] res_q, res_d;
    logic [4:0]  flags_q, flags_d;
    logic [4:0]  psr_q, psr_d;
    logic        supported;
    logic        is_lsh;
    logic [15:0] b_sel;
`ifdef ALU_SEQ_MULTISHIFT_EN
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic [3:0]  amt;
`endif

    always_comb begin
        unique case (op_q)
            4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b1001, 4'b1011, 4'b1101,
            4'b1111: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    assign is_lsh = (op_q == OP_LSH);
    assign b_sel  = imm_mode_q ? {{8{imm_q[7]}}, imm_q} : rf_rdata_b;
`ifdef ALU_SEQ_MULTISHIFT_EN
    // Magnitude of a negative amount is the 4-bit two's complement.
    assign amt = b_sel[15] ? (4'd0 - b_sel[3:0]) : b_sel[3:0];
`endif

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == WB);
    assign psr           = psr_q;
    assign rf_raddr_a    = rdest_q;
    assign rf_raddr_b    = rsrc_q;
    assign rf_waddr      = rdest_q;
    assign rf_wdata      = res_q;
    assign rf_we         = (state_q == WB) && supported && (op_q != OP_CMP);

    always_comb begin
        alu_a            = '0;
        alu_b            = '0;
        alu_op           = '0;
        alu_imm_mode     = 1'b0;
        alu_carry_in     = 1'b0;
        alu_update_flags = 1'b0;
        if (state_q == EXEC) begin
            alu_a            = opa_q;
            alu_b            = opb_q;
            alu_op           = op_q;
            alu_imm_mode     = imm_mode_q;
            alu_carry_in     = psr_q[4];
            alu_update_flags = 1'b1;
`ifndef ALU_SEQ_MULTISHIFT_EN
            // Single +/-1 pass; zero amount counts as a left shift.
            if (is_lsh) begin
                alu_imm_mode = 1'b0;
                alu_b        = opb_q[15] ? 16'hFFFF : 16'h0001;
            end
`endif
        end
`ifdef ALU_SEQ_MULTISHIFT_EN
        if (state_q == SHIFT) begin
            alu_a            = res_q;
            alu_b            = dir_q ? 16'hFFFF : 16'h0001;
            alu_op           = OP_LSH;
            alu_carry_in     = psr_q[4];
            alu_update_flags = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rdest_d     = rdest_q;
        rsrc_d      = rsrc_q;
        imm_d       = imm_q;
        imm_mode_d  = imm_mode_q;
        set_flags_d = set_flags_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        flags_d     = flags_q;
        psr_d       = psr_q;
`ifdef ALU_SEQ_MULTISHIFT_EN
        cnt_d       = cnt_q;
        dir_d       = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d        = cmd.cmd_op;
                    rdest_d     = cmd.cmd_rdest;
                    rsrc_d      = cmd.cmd_rsrc;
                    imm_d       = cmd.cmd_imm;
                    imm_mode_d  = cmd.cmd_imm_mode;
                    set_flags_d = cmd.cmd_set_flags;
                    state_d     = READ;
                end
            end
            READ: begin
                opa_d   = rf_rdata_a;
                opb_d   = b_sel;
                state_d = EXEC;
`ifdef ALU_SEQ_MULTISHIFT_EN
                if (is_lsh) begin
                    res_d = rf_rdata_a;
                    cnt_d = amt;
                    dir_d = b_sel[15];
                    if (amt == 4'd0) begin
                        flags_d = {3'b000, rf_rdata_a == 16'h0000, 1'b0};
                        state_d = WB;
                    end else begin
                        state_d = SHIFT;
                    end
                end
`endif
            end
            EXEC: begin
                res_d   = alu_result;
                flags_d = alu_flags;
                state_d = WB;
            end
`ifdef ALU_SEQ_MULTISHIFT_EN
            SHIFT: begin
                res_d   = alu_result;
                flags_d = alu_flags;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = WB;
                end
            end
`endif
            WB: begin
                if (set_flags_q && supported) begin
                    psr_d = flags_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rdest_q     <= '0;
            rsrc_q      <= '0;
            imm_q       <= '0;
            imm_mode_q  <= 1'b0;
            set_flags_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            psr_q       <= '0;
`ifdef ALU_SEQ_MULTISHIFT_EN
            cnt_q       <= '0;
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rdest_q     <= rdest_d;
            rsrc_q      <= rsrc_d;
            imm_q       <= imm_d;
            imm_mode_q  <= imm_mode_d;
            set_flags_q <= set_flags_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            psr_q       <= psr_d;
`ifdef ALU_SEQ_MULTISHIFT_EN
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
`endif
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 4 (ALU opcode); cmd_rdest in 4; cmd_rsrc in 4; cmd_imm in 8; cmd_imm_mode in 1 (operand B = immediate); cmd_set_flags in 1 (commit flags to PSR).
REQ-003 SHALL have register-file ports: rf_raddr_a out 4; rf_raddr_b out 4; rf_rdata_a in 16; rf_rdata_b in 16 (combinational read); rf_we out 1; rf_waddr out 4; rf_wdata out 16.
REQ-004 SHALL have ALU ports: alu_a out 16; alu_b out 16; alu_op out 4; alu_imm_mode out 1; alu_carry_in out 1; alu_update_flags out 1; alu_result in 16; alu_flags in 5 ({C,L,F,Z,N}).
REQ-005 SHALL have status ports: psr out 5 ({C,L,F,Z,N}); busy out 1; done out 1 (one-cycle pulse per completed command).

Function
REQ-006 SHALL implement states IDLE, READ, EXEC, SHIFT, WB.
REQ-007 cmd_ready SHALL be 1 only in IDLE; command accepted on cycle with cmd_valid & cmd_ready; all cmd_* fields latched then; IDLE->READ.
REQ-008 READ: rf_raddr_a = rdest, rf_raddr_b = rsrc; capture rdata_a into opA, rdata_b (or imm when imm_mode) into opB; READ->EXEC, or READ->SHIFT when op = 4'b0100 (LSH).
REQ-009 EXEC: drive alu_a=opA, alu_b=opB, alu_op=op, alu_imm_mode=imm_mode, alu_update_flags=1, alu_carry_in=psr[C]; capture alu_result and alu_flags; EXEC->WB.
REQ-010 Non-shift latency: done asserted exactly 3 cycles after acceptance edge; cmd_ready high again the cycle after done.
REQ-011 WB: done=1; rf_we=1, rf_waddr=rdest, rf_wdata=captured result, except rf_we=0 for CMP (4'b1011) and for unsupported opcodes (any not in {0001,0010,0011,0100,0101,1001,1011,1101,1111}); WB->IDLE.
REQ-012 psr SHALL update at the WB edge to captured flags only when set_flags=1 and opcode supported; otherwise psr holds.
REQ-013 Shift amount: S = sign-extended opB (imm sign-extended from 8 bits when imm_mode); S>=0 left by S[3:0]; S<0 right by (-S)[3:0]; direction and count latched on READ->SHIFT.
REQ-014 SHIFT: one ALU pass per cycle, alu_op=LSH, alu_imm_mode=0, alu_b=16'h0001 (left) or 16'hFFFF (right), alu_a = running value (initially opA); running value <= alu_result; count decrements; SHIFT->WB when count reaches 0 after the pass.
REQ-015 Shift count 0: READ->WB directly, result = opA, flags Z=(opA==0), others 0.
REQ-016 Shift flags: taken from the final pass only.
REQ-017 busy = 1 in every state except IDLE.
REQ-018 Outside EXEC/SHIFT: alu_update_flags=0, alu_op=4'b0000; rf_we=0 outside WB.
REQ-019 cmd_valid while busy SHALL be ignored (no latch, no side effect).

Reset
REQ-020 reset_n=0 SHALL immediately force state IDLE, psr=0, rf_we=0, done=0, busy=0, cmd_ready=1 after deassertion, all internal operand/count registers 0.
REQ-021 Reset mid-command SHALL abort it with no register write and no psr change after release.

Configuration
REQ-022 Macro ALU_SEQ_MULTISHIFT_EN defined: multi-bit shift per REQ-013..016.
REQ-023 Macro undefined: SHIFT state absent; LSH handled in EXEC with exactly one ±1 pass, direction = sign of S, S=0 treated as left by 1; latency equals REQ-010.

Verification
REQ-024 R1=16'h7FFF, R2=16'h0001, ADD R1,R2 set_flags -> done 3 cycles after accept, R1=16'h8000, psr F=1, C=0, Z=0.
REQ-025 R3=5, CMP R3,imm 8'hFB (-5) set_flags -> rf_we never 1, psr L=1 (5<65531 unsigned), N=0, Z=0.
REQ-026 (MULTISHIFT_EN) R4=16'h0001, LSH imm 8'h04 -> R4=16'h0010, done 6 cycles after accept; LSH imm 8'hFE on 16'h8000 -> 16'h2000.
REQ-027 (MULTISHIFT_EN) LSH amount 0 on R5=0, set_flags -> R5=0, psr Z=1, done 2 cycles after accept.
REQ-028 Assert reset_n=0 during SHIFT of 16'h00FF -> rf_we stays 0, psr=0, cmd_ready=1 after release, register unchanged.
REQ-029 cmd_valid held high through busy cycles with changing fields -> only the first accepted command executes.
